fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
//  Owns the PC, drives the instruction-memory request and latches fetched words.
//  Presents the instruction word and PC+4 to the decode stage; the decoder reads ifid_instr.
//  Accepts stall and flush/redirect from hazard logic, and halt from decode.
// PARAMETERS
//  PC_INIT   32'h0000_0000  PC value loaded on reset
//  CNT_W     32             width of retired-fetch counter fetch_count
// PORTS
//  CLK           in   1      clock; all state updates on rising edge
//  nRST          in   1      synchronous active-low reset
//  ihit          in   1      imem returns a valid word for imemaddr this cycle
//  imemload      in   32     instruction word, valid when ihit=1
//  stall         in   1      hazard unit: hold PC and IF/ID register
//  flush         in   1      taken branch/jump resolved downstream; redirect now
//  redirect_pc   in   32     new PC, sampled when flush=1
//  halt_in       in   1      decode saw HALT (0xFFFFFFFF) in ifid_instr
//  imemREN       out  1      instruction read enable
//  imemaddr      out  32     fetch address = pc (combinational from pc register)
//  ifid_instr    out  32     latched instruction; 0 (sll $0,$0,0 NOP) when bubble
//  ifid_pcplus4  out  32     latched PC+4 of ifid_instr
//  ifid_valid    out  1      ifid_instr is a real fetched instruction
//  halted        out  1      fetch stopped by HALT
//  fetch_count   out  CNT_W  count of words latched into IF/ID
// BEHAVIOUR
//  - Reset (nRST=0 at posedge): pc=PC_INIT; ifid_instr=0; ifid_pcplus4=0; ifid_valid=0;
//    state=FETCH; fetch_count=0. Reset mid-stall/mid-halt returns to FETCH the next cycle.
//  - States: FETCH (imemREN=1) and HALTED (imemREN=0, halted=1). imemaddr=pc always.
//  - Per-cycle priority when nRST=1, highest first:
//    1 flush: pc<=redirect_pc with [1:0] forced to 00; IF/ID<=bubble; state<=FETCH.
//      Flush in HALTED leaves HALTED, because the halt was wrong-path.
//      Flush overrides stall, halt_in and ihit in the same cycle.
//      The ihit word is discarded and pc is not incremented.
//    2 halt_in & !stall & state==FETCH: state<=HALTED; IF/ID<=bubble; pc holds.
//      halt_in is ignored while stall=1 and is evaluated again once stall drops.
//    3 stall: pc, IF/ID, fetch_count all hold; ihit this cycle is ignored.
//      The same address is re-fetched after the stall.
//    4 state==FETCH & ihit: pc<=pc+4 (mod 2^32, 0xFFFFFFFC wraps to 0).
//      IF/ID<={imemload, pc+4, valid=1}; fetch_count+=1 (wraps).
//    5 state==FETCH & !ihit: IF/ID<=bubble; pc holds, request stays asserted.
//    6 HALTED without flush: everything holds; imemREN=0; ihit is ignored.
//  - Bubble = {ifid_instr=0, ifid_pcplus4=0, ifid_valid=0}.
//  - Latency: a word returned with ihit at edge N appears on ifid_* after edge N.
//    With no stalls and ihit=1 every cycle, throughput is one instruction per cycle.
//  - Outputs are registered except imemaddr and imemREN, which decode from pc and state.
// TESTING
//  1 Reset, then ihit=1 for 3 cycles with imemload=A,B,C:
//    imemaddr 0,4,8,C; ifid_instr A,B,C; ifid_pcplus4 4,8,C; fetch_count 3.
//  2 ihit=0 for 2 cycles mid-stream: ifid_valid=0 both cycles; imemaddr stays 0x8; no count.
//  3 stall=1 with ihit=1 for 2 cycles: ifid_* and pc frozen; after release, same address
//    is re-fetched and latched once.
//  4 flush=1, redirect_pc=0x103, with stall=1 and ihit=1 in the same cycle:
//    next imemaddr=0x100; ifid_valid=0.
//  5 halt_in=1: halted=1, imemREN=0 and holds for 10 cycles.
//    Then flush with redirect_pc=0x40 gives halted=0 and imemaddr=0x40.
//  6 pc=0xFFFFFFFC with ihit=1: ifid_pcplus4=0 and next imemaddr=0.
//    Assert nRST=0 while HALTED: pc=PC_INIT and state=FETCH one cycle later.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage and IF/ID pipeline register of the
//             pipelined MIPS core. Owns the PC, drives the instruction-memory
//             read request and latches returned words into IF/ID together
//             with PC+4 for the decode stage.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PC_INIT       PC value loaded on reset
//    CNT_W         width of the retired-fetch counter fetch_count
//  Ports
//    CLK           in   1      clock, all state updates on rising edge
//    nRST          in   1      synchronous active-low reset
//    ihit          in   1      imem returns a valid word for imemaddr
//    imemload      in   32     instruction word, valid when ihit=1
//    stall         in   1      hold PC and IF/ID register
//    flush         in   1      redirect fetch to redirect_pc now
//    redirect_pc   in   32     new PC, sampled when flush=1
//    halt_in       in   1      decode saw HALT in ifid_instr
//    imemREN       out  1      instruction read enable
//    imemaddr      out  32     fetch address (= pc)
//    ifid_instr    out  32     latched instruction, 0 (NOP) for a bubble
//    ifid_pcplus4  out  32     latched PC+4 of ifid_instr
//    ifid_valid    out  1      ifid_instr is a real fetched instruction
//    halted        out  1      fetch stopped by HALT
//    fetch_count   out  CNT_W  number of words latched into IF/ID
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int          CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic [31:0]      imemload,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      redirect_pc,
   input  logic             halt_in,
   output logic             imemREN,
   output logic [31:0]      imemaddr,
   output logic [31:0]      ifid_instr,
   output logic [31:0]      ifid_pcplus4,
   output logic             ifid_valid,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [0:0] ST_FETCH  = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   localparam logic [31:0] C_NOP = 32'h0000_0000;

   // ------------------------------------------------------------------------
   // Registers and next-state values
   // ------------------------------------------------------------------------
   logic [0:0]       state_q,    state_d;
   logic [31:0]      pc_q,       pc_d;
   logic [31:0]      instr_q,    instr_d;
   logic [31:0]      pcplus4_q,  pcplus4_d;
   logic             valid_q,    valid_d;
   logic [CNT_W-1:0] count_q,    count_d;

   logic [31:0]      w_pc_plus4;
   logic             w_in_fetch;

   // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0.
   assign w_pc_plus4 = pc_q + 32'd4;
   assign w_in_fetch = (state_q == ST_FETCH);

   // ------------------------------------------------------------------------
   // Next-state logic, priority flush > halt > stall > hit > miss > halted
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
      count_d   = count_q;

      if (flush) begin
         // Redirect wins over everything. Any word returned this cycle
         // belongs to the wrong path and is dropped. A HALTED state is also
         // abandoned, since the HALT itself was fetched down the wrong path.
         state_d   = ST_FETCH;
         pc_d      = {redirect_pc[31:2], 2'b00};
         instr_d   = C_NOP;
         pcplus4_d = 32'd0;
         valid_d   = 1'b0;
      end else if (halt_in && !stall && w_in_fetch) begin
         // Halt only takes effect once the pipeline is moving, so a stalled
         // HALT is re-evaluated when the stall drops.
         state_d   = ST_HALTED;
         instr_d   = C_NOP;
         pcplus4_d = 32'd0;
         valid_d   = 1'b0;
      end else if (stall) begin
         // Full hold; the same address is requested again afterwards, so a
         // word returned during the stall is simply re-fetched later.
         state_d = state_q;
      end else if (w_in_fetch && ihit) begin
         pc_d      = w_pc_plus4;
         instr_d   = imemload;
         pcplus4_d = w_pc_plus4;
         valid_d   = 1'b1;
         count_d   = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (w_in_fetch) begin
         // Miss: keep requesting the same address, feed decode a bubble.
         instr_d   = C_NOP;
         pcplus4_d = 32'd0;
         valid_d   = 1'b0;
      end
      // HALTED without flush: everything holds.
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q   <= ST_FETCH;
         pc_q      <= PC_INIT;
         instr_q   <= C_NOP;
         pcplus4_q <= 32'd0;
         valid_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign imemREN      = w_in_fetch;
   assign imemaddr     = pc_q;
   assign ifid_instr   = instr_q;
   assign ifid_pcplus4 = pcplus4_q;
   assign ifid_valid   = valid_q;
   assign halted       = (state_q == ST_HALTED);
   assign fetch_count  = count_q;

endmodule
`default_nettype wire
